// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser, frames sent back-to-back.
// Latency: word written into an empty idle FIFO at edge E0 is popped at E1; start bit on the line after E1.
// Backpressure: o_TX_Ready low while FIFO full; a write while full is dropped and flagged on o_Overflow.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         i_Clock,
    input  logic                         i_Rst_L,
    input  logic                         i_TX_DV,
    input  logic [DATA_BITS-1:0]         i_TX_Data,
    input  logic [1:0]                   i_Parity_Mode,
    input  logic                         i_Two_Stop,
    output logic                         o_TX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]  o_FIFO_Count,
    output logic                         o_Overflow,
    output logic                         o_TX_Active,
    output logic                         o_TX_Serial,
    output logic                         o_TX_Done
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_FW-1:0]    count;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    state_t               state, state_d;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx, bit_idx_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic [1:0]           mode, mode_d;
    logic                 two_stop, two_stop_d;
    logic                 stop_idx, stop_idx_d;
    logic                 par_bit, par_bit_d;
    logic                 serial_d;
    logic                 load;
    logic                 bit_end;
    logic                 last_stop;

    assign o_TX_Ready   = (count != CNT_FW'(FIFO_DEPTH));
    assign o_FIFO_Count = count;
    assign fifo_empty   = (count == '0);
    assign push         = i_TX_DV && o_TX_Ready;
    assign pop          = load;
    assign head         = mem[rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count + CNT_FW'(push) - CNT_FW'(pop);
            o_Overflow <= i_TX_DV && !o_TX_Ready;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) mem[wr_ptr] <= i_TX_Data;
    end

    always_comb begin
        case (i_Parity_Mode)
            2'b01:   head_par = ~^head;
            2'b10:   head_par = ^head;
            2'b11:   head_par = 1'b1;
            default: head_par = 1'b0;
        endcase
    end

    assign bit_end     = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    // stop_idx counts stop bits already finished; the last one is index 1 only with two stops
    assign last_stop   = (stop_idx == two_stop);
    assign o_TX_Active = (state != IDLE);
    assign o_TX_Done   = (state == STOP) && bit_end && last_stop;

    always_comb begin
        state_d    = state;
        clk_cnt_d  = clk_cnt;
        bit_idx_d  = bit_idx;
        shift_d    = shift;
        mode_d     = mode;
        two_stop_d = two_stop;
        stop_idx_d = stop_idx;
        par_bit_d  = par_bit;
        serial_d   = o_TX_Serial;
        load       = 1'b0;

        if (state != IDLE) clk_cnt_d = bit_end ? '0 : clk_cnt + CNT_W'(1);

        case (state)
            IDLE: begin
                serial_d = 1'b1;
                load     = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    serial_d  = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        stop_idx_d = 1'b0;
                        if (mode != 2'b00) begin
                            state_d  = PARITY;
                            serial_d = par_bit;
                        end else begin
                            state_d  = STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx + IDX_W'(1);
                        shift_d   = shift >> 1;
                        serial_d  = shift[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                    serial_d   = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!last_stop) begin
                        stop_idx_d = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        serial_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame settings are captured at pop time so mid-frame input changes only affect the next frame
        if (load) begin
            state_d    = START;
            clk_cnt_d  = '0;
            shift_d    = head;
            mode_d     = i_Parity_Mode;
            two_stop_d = i_Two_Stop;
            par_bit_d  = head_par;
            serial_d   = 1'b0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            mode        <= 2'b00;
            two_stop    <= 1'b0;
            stop_idx    <= 1'b0;
            par_bit     <= 1'b0;
            o_TX_Serial <= 1'b1;
        end else begin
            state       <= state_d;
            clk_cnt     <= clk_cnt_d;
            bit_idx     <= bit_idx_d;
            shift       <= shift_d;
            mode        <= mode_d;
            two_stop    <= two_stop_d;
            stop_idx    <= stop_idx_d;
            par_bit     <= par_bit_d;
            o_TX_Serial <= serial_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed and random bursts checked against a frame-level waveform model.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int W   = 2048;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] m;
        logic       t;
    } frame_t;

    logic       clk;
    logic       rst_l;
    logic       dv;
    logic [7:0] data;
    logic [1:0] par_mode;
    logic       two_stop;
    logic       ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       active;
    logic       serial;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic         cap_en;
    int           cap_n;
    logic [W-1:0] cap_ser, cap_act, cap_done, cap_ovf;
    logic [W-1:0] exp_ser, exp_act, exp_done, exp_mask;
    int           exp_n;
    frame_t       exp_frames[$];
    logic [7:0]   tx_words[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_TX_DV(dv), .i_TX_Data(data),
        .i_Parity_Mode(par_mode), .i_Two_Stop(two_stop), .o_TX_Ready(ready),
        .o_FIFO_Count(fifo_count), .o_Overflow(overflow), .o_TX_Active(active),
        .o_TX_Serial(serial), .o_TX_Done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!cap_en) begin
            cap_n    <= 0;
            cap_ser  <= '0;
            cap_act  <= '0;
            cap_done <= '0;
            cap_ovf  <= '0;
        end else if (cap_n < W) begin
            cap_ser[cap_n]  <= serial;
            cap_act[cap_n]  <= active;
            cap_done[cap_n] <= done;
            cap_ovf[cap_n]  <= overflow;
            cap_n           <= cap_n + 1;
        end
    end

    // Reference: each frame is a list of line levels (start, data LSB first, parity, stops), each held CPB cycles
    task automatic build_model();
        int p = 0;
        exp_ser = '0; exp_act = '0; exp_done = '0; exp_mask = '0;
        foreach (exp_frames[f]) begin
            logic bits[$];
            int ones = $countones(exp_frames[f].d);
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(exp_frames[f].d[i]);
            if (exp_frames[f].m == 2'b11)      bits.push_back(1'b1);
            else if (exp_frames[f].m == 2'b10) bits.push_back(ones % 2 == 1);
            else if (exp_frames[f].m == 2'b01) bits.push_back(ones % 2 == 0);
            bits.push_back(1'b1);
            if (exp_frames[f].t) bits.push_back(1'b1);
            foreach (bits[b]) begin
                for (int c = 0; c < CPB; c++) begin
                    exp_ser[p] = bits[b];
                    exp_act[p] = 1'b1;
                    p++;
                end
            end
            exp_done[p-1] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            exp_ser[p] = 1'b1;
            p++;
        end
        exp_n = p;
        for (int i = 0; i < exp_n; i++) exp_mask[i] = 1'b1;
    endtask

    task automatic add_frame(input logic [7:0] d, input logic [1:0] m, input logic t);
        frame_t f;
        f.d = d; f.m = m; f.t = t;
        exp_frames.push_back(f);
    endtask

    function automatic int find_start();
        for (int i = 0; i < cap_n; i++) if (cap_act[i] === 1'b1) return i;
        return W - 1;
    endfunction

    function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < W; i++) if (a[i] !== b[i]) return i;
        return 0;
    endfunction

    task automatic do_reset();
        cap_en = 1'b0; dv = 1'b0; data = 8'h00; rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Writes tx_words on consecutive edges; capture sample 0 is the cycle after the first write
    task automatic send_burst(input int n);
        for (int k = 0; k < n; k++) begin
            dv = 1'b1; data = tx_words[k];
            @(posedge clk);
            #1;
            if (k == 0) cap_en = 1'b1;
        end
        dv = 1'b0;
    endtask

    task automatic test_reset();
        par_mode = 2'b00; two_stop = 1'b0;
        do_reset();
        checks++; if (serial !== 1'b1)     begin errors++; $display("FAIL reset_serial: got %b want 1", serial); end
        checks++; if (active !== 1'b0)     begin errors++; $display("FAIL reset_active: got %b want 0", active); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (ready !== 1'b1)      begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    endtask

    task automatic test_basic();
        int s, d;
        logic [W-1:0] w;
        par_mode = 2'b00; two_stop = 1'b0;
        do_reset();
        tx_words.delete(); tx_words.push_back(8'h55);
        send_burst(1);
        checks++; if (serial !== 1'b1 || fifo_count !== 3'd1)
            begin errors++; $display("FAIL basic_before_pop: serial %b count %0d want 1 1", serial, fifo_count); end
        wait_cyc(1);
        checks++; if (serial !== 1'b0 || fifo_count !== 3'd0 || active !== 1'b1)
            begin errors++; $display("FAIL basic_after_pop: serial %b count %0d active %b want 0 0 1", serial, fifo_count, active); end
        wait_cyc(50);
        exp_frames.delete(); add_frame(8'h55, 2'b00, 1'b0);
        build_model();
        s = find_start();
        checks++; if (s != 1) begin errors++; $display("FAIL basic_latency: start sample %0d want 1", s); end
        w = (cap_ser >> s) & exp_mask;
        checks++; if (w !== exp_ser) begin errors++; d = first_diff(w, exp_ser);
            $display("FAIL basic_line: cycle %0d got %b want %b", d, w[d], exp_ser[d]); end
        w = (cap_done >> s) & exp_mask;
        checks++; if (w !== exp_done) begin errors++; d = first_diff(w, exp_done);
            $display("FAIL basic_done: cycle %0d got %b want %b", d, w[d], exp_done[d]); end
        checks++; if ($countones(cap_act) != 40) begin errors++; $display("FAIL basic_active_len: got %0d want 40", $countones(cap_act)); end
    endtask

    task automatic test_parity(input logic [7:0] d8, input logic [1:0] m, input logic t,
                               input logic exp_par, input int exp_len, input string name);
        int s, d;
        logic [W-1:0] w;
        par_mode = m; two_stop = t;
        do_reset();
        tx_words.delete(); tx_words.push_back(d8);
        send_burst(1);
        wait_cyc(exp_len + 12);
        exp_frames.delete(); add_frame(d8, m, t);
        build_model();
        s = find_start();
        w = (cap_ser >> s) & exp_mask;
        checks++; if (w !== exp_ser) begin errors++; d = first_diff(w, exp_ser);
            $display("FAIL %s_line: cycle %0d got %b want %b", name, d, w[d], exp_ser[d]); end
        checks++; if (cap_ser[s + 9*CPB + 1] !== exp_par)
            begin errors++; $display("FAIL %s_parity_bit: got %b want %b", name, cap_ser[s + 9*CPB + 1], exp_par); end
        checks++; if ($countones(cap_act) != exp_len)
            begin errors++; $display("FAIL %s_frame_len: got %0d want %0d", name, $countones(cap_act), exp_len); end
        w = (cap_done >> s) & exp_mask;
        checks++; if (w !== exp_done) begin errors++; d = first_diff(w, exp_done);
            $display("FAIL %s_done: cycle %0d got %b want %b", name, d, w[d], exp_done[d]); end
    endtask

    task automatic test_back_to_back();
        int s, d;
        logic [W-1:0] w;
        logic [7:0] words[6];
        par_mode = 2'b00; two_stop = 1'b0;
        do_reset();
        exp_frames.delete();
        for (int k = 0; k < 6; k++) words[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 5; k++) begin
            dv = 1'b1; data = words[k];
            @(posedge clk);
            #1;
            if (k == 0) cap_en = 1'b1;
            add_frame(words[k], 2'b00, 1'b0);
        end
        checks++; if (ready !== 1'b0 || fifo_count !== 3'd4)
            begin errors++; $display("FAIL b2b_full: ready %b count %0d want 0 4", ready, fifo_count); end
        data = words[5];
        @(posedge clk);
        #1;
        dv = 1'b0;
        checks++; if (overflow !== 1'b1 || fifo_count !== 3'd4)
            begin errors++; $display("FAIL b2b_overflow: overflow %b count %0d want 1 4", overflow, fifo_count); end
        wait_cyc(220);
        build_model();
        s = find_start();
        w = (cap_ser >> s) & exp_mask;
        checks++; if (w !== exp_ser) begin errors++; d = first_diff(w, exp_ser);
            $display("FAIL b2b_line: cycle %0d got %b want %b", d, w[d], exp_ser[d]); end
        w = (cap_act >> s) & exp_mask;
        checks++; if (w !== exp_act) begin errors++; d = first_diff(w, exp_act);
            $display("FAIL b2b_active: cycle %0d got %b want %b", d, w[d], exp_act[d]); end
        checks++; if ($countones(cap_done) != 5) begin errors++; $display("FAIL b2b_done_count: got %0d want 5", $countones(cap_done)); end
        checks++; if ($countones(cap_ovf) != 1) begin errors++; $display("FAIL b2b_overflow_pulses: got %0d want 1", $countones(cap_ovf)); end
    endtask

    task automatic test_mid_change();
        int s, d;
        logic [W-1:0] w;
        logic [7:0] d0, d1;
        d0 = 8'($urandom_range(0, 255)); d1 = 8'($urandom_range(0, 255));
        par_mode = 2'b00; two_stop = 1'b0;
        do_reset();
        tx_words.delete(); tx_words.push_back(d0); tx_words.push_back(d1);
        send_burst(2);
        wait_cyc(20);
        par_mode = 2'b01; two_stop = 1'b1;
        wait_cyc(100);
        exp_frames.delete(); add_frame(d0, 2'b00, 1'b0); add_frame(d1, 2'b01, 1'b1);
        build_model();
        s = find_start();
        w = (cap_ser >> s) & exp_mask;
        checks++; if (w !== exp_ser) begin errors++; d = first_diff(w, exp_ser);
            $display("FAIL midchange_line: cycle %0d got %b want %b", d, w[d], exp_ser[d]); end
        w = (cap_done >> s) & exp_mask;
        checks++; if (w !== exp_done) begin errors++; d = first_diff(w, exp_done);
            $display("FAIL midchange_done: cycle %0d got %b want %b", d, w[d], exp_done[d]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] m;
        par_mode = 2'b10; two_stop = 1'b0;
        do_reset();
        tx_words.delete();
        for (int k = 0; k < 3; k++) tx_words.push_back(8'($urandom_range(0, 255)));
        send_burst(3);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rstmid_queued: got %0d want 2", fifo_count); end
        wait_cyc(11);
        rst_l = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (serial !== 1'b1 || fifo_count !== 3'd0 || active !== 1'b0)
            begin errors++; $display("FAIL rstmid_after_edge: serial %b count %0d active %b want 1 0 0", serial, fifo_count, active); end
        rst_l = 1'b1;
        cap_en = 1'b0;
        wait_cyc(1);
        cap_en = 1'b1;
        wait_cyc(100);
        m = '0;
        for (int i = 0; i < 96; i++) m[i] = 1'b1;
        checks++; if ((cap_ser & m) !== m || (cap_act & m) !== '0)
            begin errors++; $display("FAIL rstmid_no_frames: line lows %0d active highs %0d want 0 0", 96 - $countones(cap_ser & m), $countones(cap_act & m)); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rstmid_count_after: got %0d want 0", fifo_count); end
    endtask

    task automatic test_random();
        int s, d, n;
        logic [W-1:0] w;
        for (int b = 0; b < 8; b++) begin
            par_mode = 2'($urandom_range(0, 3));
            two_stop = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 5);
            do_reset();
            tx_words.delete(); exp_frames.delete();
            for (int k = 0; k < n; k++) begin
                tx_words.push_back(8'($urandom_range(0, 255)));
                add_frame(tx_words[k], par_mode, two_stop);
            end
            build_model();
            send_burst(n);
            wait_cyc(exp_n + 12);
            s = find_start();
            w = (cap_ser >> s) & exp_mask;
            checks++; if (w !== exp_ser) begin errors++; d = first_diff(w, exp_ser);
                $display("FAIL rand%0d_line: cycle %0d got %b want %b", b, d, w[d], exp_ser[d]); end
            w = (cap_done >> s) & exp_mask;
            checks++; if (w !== exp_done) begin errors++; d = first_diff(w, exp_done);
                $display("FAIL rand%0d_done: cycle %0d got %b want %b", b, d, w[d], exp_done[d]); end
            checks++; if (fifo_count !== 3'd0 || ready !== 1'b1 || active !== 1'b0)
                begin errors++; $display("FAIL rand%0d_drained: count %0d ready %b active %b want 0 1 0", b, fifo_count, ready, active); end
        end
    endtask

    initial begin
        rst_l = 1'b0; dv = 1'b0; data = 8'h00; par_mode = 2'b00; two_stop = 1'b0; cap_en = 1'b0;
        test_reset();
        test_basic();
        test_parity(8'h07, 2'b10, 1'b0, 1'b1, 44, "even");
        test_parity(8'h07, 2'b01, 1'b0, 1'b0, 44, "odd");
        test_parity(8'h00, 2'b11, 1'b0, 1'b1, 44, "mark");
        test_parity(8'hA3, 2'b10, 1'b1, 1'b0, 48, "even_two_stop");
        test_back_to_back();
        test_mid_change();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a byte FIFO in front of the serialiser. The data width, FIFO depth and bit period are set by parameters. Parity mode and stop-bit count are selected at run time, per frame. It sits between the host-side byte producers and the TX pad, and sends back-to-back frames with no idle gap while the FIFO holds data.

Parameters:
CLKS_PER_BIT, 217, clock cycles per serial bit (fclk/baud), must be >= 2.
DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first.
FIFO_DEPTH, 4, FIFO entries, must be a power of two and >= 2.

Ports:
i_Clock  in  1  system clock, all logic on rising edge.
i_Rst_L  in  1  reset, synchronous, active-low.
i_TX_DV  in  1  write strobe; a word is accepted on an edge where i_TX_DV=1 and o_TX_Ready=1.
i_TX_Data  in  DATA_BITS  word to enqueue.
i_Parity_Mode  in  2  parity mode: 00 none, 01 odd, 10 even, 11 mark (parity bit always 1).
i_Two_Stop  in  1  0 = one stop bit, 1 = two stop bits.
o_TX_Ready  out  1  FIFO not full.
o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
o_Overflow  out  1  one-cycle pulse when i_TX_DV=1 while o_TX_Ready=0; that word is dropped.
o_TX_Active  out  1  high from the first start-bit cycle to the last stop-bit cycle of a burst.
o_TX_Serial  out  1  serial line, idles high.
o_TX_Done  out  1  one-cycle pulse in the final cycle of each frame's last stop bit.

Behaviour:
- Reset (i_Rst_L=0 at an edge):
  - o_TX_Serial=1; o_TX_Active=0, o_TX_Done=0, o_Overflow=0; o_FIFO_Count=0; o_TX_Ready=1.
  - FIFO pointers clear and the FSM goes to IDLE.
  - A reset mid-frame aborts the frame; the line is high after that edge and the FIFO contents are discarded.
- FIFO:
  - Push and pop happen on the same edge. The count is updated by +push-pop.
  - o_TX_Ready is derived combinationally from the count (count != FIFO_DEPTH).
  - A push and a pop on the same edge are legal at any count below full.
  - When full, the push is refused even if a pop occurs on the same edge.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_TX_Serial=1. If the FIFO is non-empty:
    - pop the head word into the shift register;
    - latch i_Parity_Mode and i_Two_Stop for the frame (later changes do not affect a frame in flight);
    - compute the parity bit: none/mark as defined above, even = XOR of the data bits, odd = NOT of that XOR;
    - drive o_TX_Serial=0, set o_TX_Active=1, go to START.
  - Every bit lasts exactly CLKS_PER_BIT cycles. The bit counter counts 0..CLKS_PER_BIT-1 and the next bit value is driven on the edge at terminal count.
  - START -> DATA: send DATA_BITS bits, LSB first; a bit index counts 0..DATA_BITS-1.
  - DATA -> PARITY if the latched mode != 00, else -> STOP.
  - PARITY -> STOP.
  - STOP lasts 1 or 2 bit periods. In its last cycle o_TX_Done=1:
    - if the FIFO is non-empty on the terminal edge, pop the next word, drive start bit 0 immediately and stay active (zero gap);
    - otherwise go to IDLE and set o_TX_Active=0.
- Latency: a word accepted at edge E0 into an empty idle FIFO is popped at E1, and o_TX_Serial goes low after E1.
- Frame length = CLKS_PER_BIT*(1+DATA_BITS+P+S), where P is 0/1 (parity present) and S is 1/2 (stop bits).
- Counter width: $clog2(CLKS_PER_BIT) bits.
- No X may reach o_TX_Serial after reset.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, mode 00, one stop; push 0x55 -> line 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles; frame 40 cycles; o_TX_Done high only in cycle 40; o_TX_Active high for exactly 40 cycles.
- Even parity, push 0x07 -> parity bit 1, frame 44 cycles. Repeat with odd parity -> parity bit 0. Repeat with mark and 0x00 -> parity bit 1.
- Even parity, two stop bits, push 0xA3 -> parity bit 0, two stop bits of 4 cycles each, frame 48 cycles.
- From idle with FIFO_DEPTH=4, assert i_TX_DV on 6 consecutive edges:
  - the first 5 words are accepted (one is popped at E1);
  - 6th edge: o_TX_Ready=0, o_Overflow pulses once, o_FIFO_Count=4;
  - all 5 frames go out with no high gap between stop and start;
  - o_TX_Active stays high throughout and o_TX_Done pulses 5 times.
- Change i_Parity_Mode and i_Two_Stop mid-frame -> the current frame is unchanged and the next frame uses the new values.
- Assert i_Rst_L=0 during bit 3 of a frame with 2 words queued -> o_TX_Serial=1, o_FIFO_Count=0, o_TX_Active=0 after the edge, and no further frames are sent.
